frame_rotator: RTL and testbench

Parametrised full-frame pixel rotator.
- Buffers one IMG_W x IMG_H frame, received in raster order, into an internal single-port SRAM.
- Streams the frame back out in raster order of the rotated image: 0, 90 CCW, 180 or 90 CW.
- Uses valid/ready handshakes on both sides and supports non-square frames, swapping output dimensions for 90-degree modes.
- Sits between the pixel source and the downstream image pipeline, in the slot of the fixed 256x256 CCW adapter.

---
 rtl/frame_rotator_pkg.sv | 27 ++
 rtl/frame_rotator_if.sv | 19 +
 rtl/frame_rotator_sram.sv | 21 ++
 rtl/frame_rotator.sv | 158 +++++++++++++++
 tb/tb_frame_rotator.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/frame_rotator_pkg.sv
// Shared types and the output-to-source coordinate mapping for frame_rotator.
package frame_rotator_pkg;

  typedef enum logic [1:0] {ROT_0, ROT_CCW90, ROT_180, ROT_CW90} rot_e;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } coord_t;

  // w/h are the source frame dimensions; (ox,oy) walk the rotated image in raster order.
  function automatic coord_t src_coord(rot_e rot, logic [31:0] ox, logic [31:0] oy,
                                       logic [31:0] w, logic [31:0] h);
    coord_t c;
    c.x = ox;
    c.y = oy;
    case (rot)
      ROT_CCW90: begin c.x = w - 32'd1 - oy; c.y = ox;               end
      ROT_180:   begin c.x = w - 32'd1 - ox; c.y = h - 32'd1 - oy;   end
      ROT_CW90:  begin c.x = oy;             c.y = h - 32'd1 - ox;   end
      default:   begin c.x = ox;             c.y = oy;               end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_rotator_if.sv
// Pixel-in / pixel-out handshake bundle for frame_rotator.
interface frame_rotator_if #(parameter int PIX_W = 24);
  logic [1:0]       rot_sel;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_eol;
  logic             m_eof;
  logic             busy;
  logic             frame_done;

  modport master (output rot_sel, s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_eol, m_eof, busy, frame_done);
  modport slave  (input  rot_sel, s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_eol, m_eof, busy, frame_done);
endinterface

// File: rtl/frame_rotator_sram.sv
// Single-port frame store with a one-cycle synchronous read.
module rot_sram #(
    parameter int PIX_W = 24,
    parameter int AW    = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

// File: rtl/frame_rotator.sv
// Buffers one raster frame, then replays it rotated by 0/90/180/270 degrees
// through a 2-entry output FIFO fed by credit-limited SRAM reads.
module frame_rotator
    import frame_rotator_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 24
) (
    input  logic           clk,
    input  logic           rst,
    frame_rotator_if.slave io
);
    localparam int AW   = $clog2(IMG_W * IMG_H);
    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW   = $clog2(MAXD);
    localparam logic [CW-1:0] W_M1 = CW'(IMG_W - 1);
    localparam logic [CW-1:0] H_M1 = CW'(IMG_H - 1);

    state_e          state_q, state_d;
    rot_e            rot_q;
    logic [CW-1:0]   x_q, y_q, ox_q, oy_q;
    logic            rd_done_q;
    logic            s_rdy, hs_in, pop, load_last;
    logic            rd_ok, rd_vld_q, rd_eol_q, rd_eof_q;
    logic            eol, eof;
    logic [CW-1:0]   ow_m1, oh_m1;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic            sram_we;
    logic [PIX_W-1:0] rdata;
    logic [PIX_W+1:0] fifo_q [2];
    logic            wptr_q, rptr_q;
    logic [1:0]      cnt_q;
    logic            done_q;
    coord_t          src;

    assign hs_in     = io.s_valid && s_rdy;
    assign pop       = io.m_valid && io.m_ready;
    assign load_last = (state_q == LOAD) && hs_in && (x_q == W_M1) && (y_q == H_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_rdy   = !rst && (state_q != DRAIN);
        case (state_q)
            IDLE:    if (hs_in)              state_d = LOAD;
            LOAD:    if (load_last)          state_d = DRAIN;
            DRAIN:   if (pop && io.m_eof)    state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Output geometry swaps for the 90-degree modes.
    assign ow_m1 = rot_q[0] ? H_M1 : W_M1;
    assign oh_m1 = rot_q[0] ? W_M1 : H_M1;
    assign eol   = (ox_q == ow_m1);
    assign eof   = eol && (oy_q == oh_m1);

    always_comb begin
        src     = src_coord(rot_q, 32'(ox_q), 32'(oy_q), IMG_W, IMG_H);
        rd_addr = AW'(src.y) * AW'(IMG_W) + AW'(src.x);
        wr_addr = (state_q == IDLE) ? '0 : AW'(y_q) * AW'(IMG_W) + AW'(x_q);
    end

    // Credit check counts the slot freed by a same-cycle pop so a steady
    // m_ready sustains one pixel per cycle.
    assign rd_ok   = (state_q == DRAIN) && !rd_done_q &&
                     ((3'(cnt_q) + 3'(rd_vld_q)) < (3'd2 + 3'(pop)));
    assign sram_we = hs_in && (state_q != DRAIN);

    rot_sram #(.PIX_W(PIX_W), .AW(AW)) u_sram (
        .clk   (clk),
        .en    (sram_we || rd_ok),
        .we    (sram_we),
        .addr  (sram_we ? wr_addr : rd_addr),
        .wdata (io.s_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q     <= ROT_0;
            x_q       <= '0;
            y_q       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            rd_done_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_eol_q  <= 1'b0;
            rd_eof_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_ok;
            rd_eol_q <= eol;
            rd_eof_q <= eof;
            case (state_q)
                IDLE: if (hs_in) begin
                    rot_q <= rot_e'(io.rot_sel);
                    x_q   <= CW'(1);
                    y_q   <= '0;
                end
                LOAD: if (hs_in) begin
                    if (x_q == W_M1) begin
                        x_q <= '0;
                        y_q <= y_q + CW'(1);
                    end else begin
                        x_q <= x_q + CW'(1);
                    end
                    if (load_last) begin
                        ox_q      <= '0;
                        oy_q      <= '0;
                        rd_done_q <= 1'b0;
                    end
                end
                DRAIN: if (rd_ok) begin
                    if (eol) begin
                        ox_q <= '0;
                        oy_q <= oy_q + CW'(1);
                        if (eof) rd_done_q <= 1'b1;
                    end else begin
                        ox_q <= ox_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            if (rd_vld_q) begin
                fifo_q[wptr_q] <= {rd_eof_q, rd_eol_q, rdata};
                wptr_q         <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q  <= cnt_q + 2'(rd_vld_q) - 2'(pop);
            done_q <= pop && io.m_eof;
        end
    end

    assign io.s_ready    = s_rdy;
    assign io.m_valid    = (cnt_q != 2'd0);
    assign io.m_data     = fifo_q[rptr_q][PIX_W-1:0];
    assign io.m_eol      = io.m_valid && fifo_q[rptr_q][PIX_W];
    assign io.m_eof      = io.m_valid && fifo_q[rptr_q][PIX_W+1];
    assign io.busy       = (state_q != IDLE);
    assign io.frame_done = done_q;
endmodule

// File: tb/tb_frame_rotator.sv
// Scoreboard bench for frame_rotator on a 4x2 frame: all rotations, random
// handshakes, mid-frame rot_sel change, back-to-back frames, reset in DRAIN.
module tb_frame_rotator;
  localparam int W = 4, H = 2, PW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_rotator_if #(.PIX_W(PW)) io ();
  frame_rotator #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (.clk(clk), .rst(rst), .io(io));

  int n_vec = 0, n_err = 0, n_out = 0;
  logic [PW+1:0] q[$];
  logic m_rnd = 1'b0;
  // Source pixel index emitted at each output position, per rotation.
  int perm [4][8] = '{'{0,1,2,3,4,5,6,7}, '{3,7,2,6,1,5,0,4},
                      '{7,6,5,4,3,2,1,0}, '{4,0,5,1,6,2,7,3}};

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame(int base, int rot);
    int ow = rot[0] ? H : W;
    for (int i = 0; i < 8; i++)
      q.push_back({(i == 7) ? 1'b1 : 1'b0, ((i + 1) % ow == 0) ? 1'b1 : 1'b0,
                   PW'(base + perm[rot][i])});
  endtask

  task automatic send_px(int d);
    logic ok = 1'b0;
    io.s_valid = 1'b1;
    io.s_data  = PW'(d);
    for (int k = 0; k < 500 && !ok; k++) begin
      ok = io.s_ready;
      @(posedge clk); #1;
    end
    io.s_valid = 1'b0;
    if (!ok) chk("s_hs_timeout", 0, 1);
  endtask

  task automatic send_frame(int base, int rot, bit rnd_v, int rot_after);
    io.rot_sel = 2'(rot);
    push_frame(base, rot);
    for (int i = 0; i < 8; i++) begin
      while (rnd_v && $urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      send_px(base + i);
      if (i == 0 && rot_after >= 0) io.rot_sel = 2'(rot_after);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    io.m_ready = m_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic          stall = 1'b0, exp_done = 1'b0;
  logic [PW+2:0] held;
  logic [PW+1:0] e;
  always @(negedge clk) begin
    if (rst) begin
      stall    = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || io.frame_done) begin
        chk("frame_done", io.frame_done, exp_done);
        if (exp_done) chk("s_ready_after_eof", io.s_ready, 1);
      end
      exp_done = 1'b0;
      if (stall) chk("stall_stable", {io.m_valid, io.m_eof, io.m_eol, io.m_data}, held);
      if (io.m_valid) begin
        chk("s_ready_drain", io.s_ready, 0);
        chk("busy_drain", io.busy, 1);
      end
      if (io.m_valid && io.m_ready) begin
        if (q.size() == 0) chk("extra_pixel", io.m_data, 32'hdead);
        else begin
          e = q.pop_front();
          chk("pixel", {io.m_eof, io.m_eol, io.m_data}, e);
        end
        n_out++;
        if (io.m_eof) exp_done = 1'b1;
      end
      stall = io.m_valid && !io.m_ready;
      held  = {1'b1, io.m_eof, io.m_eol, io.m_data};
    end
  end

  initial begin
    int n0;
    rst = 1'b1;
    io.s_valid = 1'b0;
    io.s_data  = '0;
    io.rot_sel = 2'd0;
    io.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", io.s_ready, 0);
    chk("rst_m_valid", io.m_valid, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_eol_eof", {io.m_eol, io.m_eof}, 0);
    chk("rst_frame_done", io.frame_done, 0);
    rst = 1'b0;
    #1;
    chk("idle_s_ready", io.s_ready, 1);

    for (int r = 0; r < 4; r++) begin
      send_frame(0, r, 1'b0, -1);
      wait_empty();
    end

    m_rnd = 1'b1;
    send_frame(0, 1, 1'b1, -1);
    wait_empty();
    m_rnd = 1'b0;

    send_frame(0, 1, 1'b0, 2);
    send_frame(0, 3, 1'b0, -1);
    wait_empty();

    n0 = n_out;
    send_frame(20, 0, 1'b0, -1);
    for (int i = 0; i < 200 && n_out < n0 + 3; i++) begin @(posedge clk); #1; end
    chk("reach_3_out", (n_out >= n0 + 3) ? 1 : 0, 1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_m_valid", io.m_valid, 0);
    chk("midrst_busy", io.busy, 0);
    chk("midrst_s_ready", io.s_ready, 0);
    chk("midrst_data", {io.m_eof, io.m_eol, io.m_data}, 0);
    @(posedge clk); #1;
    chk("midrst_frame_done", io.frame_done, 0);
    rst = 1'b0;
    #1;

    send_frame(10, 0, 1'b0, -1);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
